dac_sample_seq: RTL and testbench

DAC_SAMPLE_SEQ -- requirements
Module: dac_sample_seq

---
 rtl/dac_sample_seq_if.sv | 8 +
 rtl/dac_sample_seq.sv | 58 +++++
 tb/tb_dac_sample_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dac_sample_seq_if.sv
// dac_sample_seq_if: sample word handshake between the sequencer and the DAC serializer
interface dac_sample_seq_if;
    logic [15:0] WORD;
    logic        VALID;
    logic        READY;
    modport master (output WORD, VALID, input READY);
    modport slave  (input WORD, VALID, output READY);
endinterface

// File: rtl/dac_sample_seq.sv
// dac_sample_seq: timed waveform generator (constant/ramp/triangle/square) feeding DAC words over a valid/ready handshake
module dac_sample_seq #(
    parameter logic [3:0] CMD   = 4'b1111,
    parameter int         DIV_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [DIV_W-1:0] RATE,
    input  logic [11:0]      STEP,
    input  logic [11:0]      LEVEL,
    input  logic             CLR_OVR,
    dac_sample_seq_if.master dac,
    output logic             OVERRUN
);
    logic [DIV_W-1:0] timer;
    logic [11:0]      code, next_code, tri_code;
    logic [12:0]      sum;
    logic             down, phase, next_down, next_phase, tick, tri_top, tri_bot;
    always_comb begin
        tick       = EN && timer == RATE;
        sum        = {1'b0, code} + {1'b0, STEP};
        tri_top    = sum >= 13'd4095;
        tri_bot    = code <= STEP;
        // a zero step freezes the triangle entirely, including its direction
        tri_code   = STEP == 12'd0 ? code : down ? (tri_bot ? 12'h000 : code - STEP) : (tri_top ? 12'hfff : sum[11:0]);
        next_down  = MODE == 2'b10 && STEP != 12'd0 ? (down ? !tri_bot : tri_top) : down;
        next_phase = MODE == 2'b11 ? !phase : phase;
        next_code  = MODE == 2'b00 ? LEVEL : MODE == 2'b01 ? sum[11:0] : MODE == 2'b10 ? tri_code : (next_phase ? LEVEL : 12'h000);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            timer     <= '0;
            code      <= '0;
            down      <= 1'b0;
            phase     <= 1'b0;
            dac.WORD  <= {CMD, 12'h000};
            dac.VALID <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            timer <= tick || !EN ? '0 : timer + 1'b1;
            if (!EN) begin
                code  <= '0;
                down  <= 1'b0;
                phase <= 1'b0;
            end else if (tick) begin
                code  <= next_code;
                down  <= next_down;
                phase <= next_phase;
            end
            if (tick) dac.WORD <= {CMD, next_code};
            dac.VALID <= tick ? 1'b1 : dac.VALID && !dac.READY;
            // an overwrite in the same cycle as a clear request keeps the flag set
            OVERRUN   <= tick && dac.VALID && !dac.READY ? 1'b1 : CLR_OVR ? 1'b0 : OVERRUN;
        end
    end
endmodule

// File: tb/tb_dac_sample_seq.sv
// tb_dac_sample_seq: random and directed checks of dac_sample_seq against a cycle-level behavioural model
module tb_dac_sample_seq;
    localparam logic [3:0] CMD = 4'hF;
    logic        clk, rst, en, clr_ovr, overrun;
    logic [1:0]  mode;
    logic [15:0] rate;
    logic [11:0] stp, level;
    dac_sample_seq_if bus();
    dac_sample_seq #(.CMD(CMD), .DIV_W(16)) dut (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .RATE(rate), .STEP(stp),
        .LEVEL(level), .CLR_OVR(clr_ovr), .dac(bus), .OVERRUN(overrun)
    );
    int n_checks = 0, n_err = 0;
    int m_cnt = 0, m_code = 0;
    bit m_down = 0, m_hi = 0, m_valid = 0, m_ovr = 0;
    logic [15:0] m_word = 16'hF000;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    // one clock: predict from the pre-edge inputs, advance, then compare all outputs
    task automatic cycle();
        bit tk, nd, nh;
        int nc, s, lv, c2;
        logic [31:0] ncv;
        s  = int'(stp);
        lv = int'(level);
        tk = en && m_cnt == int'(rate);
        nc = m_code; nd = m_down; nh = m_hi;
        if (tk) begin
            case (mode)
                2'd0: nc = lv;
                2'd1: nc = (m_code + s) % 4096;
                2'd2: if (s != 0) begin
                    if (!m_down) begin
                        if (m_code + s >= 4095) begin nc = 4095; nd = 1; end else nc = m_code + s;
                    end else begin
                        if (m_code <= s) begin nc = 0; nd = 0; end else nc = m_code - s;
                    end
                end
                default: begin nh = !m_hi; nc = nh ? lv : 0; end
            endcase
        end
        @(posedge clk);
        if (rst) begin
            m_cnt = 0; m_code = 0; m_down = 0; m_hi = 0;
            m_word = {CMD, 12'h000}; m_valid = 0; m_ovr = 0;
        end else begin
            m_ovr = (tk && m_valid && !bus.READY) ? 1'b1 : clr_ovr ? 1'b0 : m_ovr;
            m_valid = tk ? 1'b1 : (m_valid && bus.READY) ? 1'b0 : m_valid;
            ncv = nc;
            if (tk) m_word = {CMD, ncv[11:0]};
            if (!en) begin m_cnt = 0; m_code = 0; m_down = 0; m_hi = 0; end
            else begin m_cnt = tk ? 0 : m_cnt + 1; m_code = nc; m_down = nd; m_hi = nh; end
        end
        c2 = m_code;
        #1;
        check("word", bus.WORD, m_word);
        check("valid", bus.VALID, m_valid);
        check("overrun", overrun, m_ovr);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask
    initial begin
        logic [11:0] tri_exp [7];
        logic [15:0] ramp_exp [5];
        int k;
        bit prev;
        tri_exp  = '{12'h600, 12'hC00, 12'hFFF, 12'h9FF, 12'h3FF, 12'h000, 12'h600};
        ramp_exp = '{16'hF400, 16'hF800, 16'hFC00, 16'hF000, 16'hF400};
        rst = 1'b1; en = 1'b1; mode = 2'b01; rate = 16'd3; stp = 12'h400;
        level = 12'h000; clr_ovr = 1'b0; bus.READY = 1'b1;
        cycle();
        cycle();
        check("rst_word", bus.WORD, 16'hF000);
        check("rst_valid", bus.VALID, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        rst = 1'b0;
        k = 0; prev = 0;
        for (int i = 0; i < 22; i++) begin
            cycle();
            if (i == 2) check("first_tick_early", bus.VALID, 1'b0);
            if (i == 3) check("first_tick", bus.VALID, 1'b1);
            if (bus.VALID && !prev) begin
                if (k < 5) check("ramp_word", bus.WORD, ramp_exp[k]);
                k++;
            end
            prev = bus.VALID;
        end
        check("ramp_count", k, 5);
        mode = 2'b10; rate = 16'd0; stp = 12'h600;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle();
            check("tri_code", bus.WORD[11:0], tri_exp[i]);
            check("tri_ovr", overrun, 1'b0);
        end
        mode = 2'b00; rate = 16'd2; level = 12'h123; bus.READY = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) cycle();
        check("bp_word", bus.WORD, 16'hF123);
        check("bp_valid", bus.VALID, 1'b1);
        check("bp_ovr", overrun, 1'b1);
        clr_ovr = 1'b1;
        cycle();
        check("clr_ovr", overrun, 1'b0);
        cycle();
        cycle();
        check("ovr_wins", overrun, 1'b1);
        clr_ovr = 1'b0;
        rst = 1'b1;
        cycle();
        check("mid_rst_word", bus.WORD, 16'hF000);
        check("mid_rst_valid", bus.VALID, 1'b0);
        check("mid_rst_ovr", overrun, 1'b0);
        rst = 1'b0;
        mode = 2'b11; rate = 16'd1; level = 12'hABC; bus.READY = 1'b1;
        do_reset();
        cycle(); cycle();
        check("sq_hi", bus.WORD, 16'hFABC);
        cycle(); cycle();
        check("sq_lo", bus.WORD, 16'hF000);
        en = 1'b0;
        cycle();
        check("sq_en_hold", bus.WORD, 16'hF000);
        en = 1'b1;
        cycle();
        check("sq_restart_wait", bus.VALID, 1'b0);
        cycle();
        check("sq_restart", bus.WORD, 16'hFABC);
        check("sq_restart_valid", bus.VALID, 1'b1);
        for (int seg = 0; seg < 40; seg++) begin
            rate = 16'($urandom_range(0, 3));
            do_reset();
            for (int i = 0; i < 20; i++) begin
                en        = $urandom_range(0, 9) != 0;
                mode      = 2'($urandom);
                stp       = $urandom_range(0, 3) == 0 ? 12'h000 : 12'($urandom);
                level     = 12'($urandom);
                bus.READY = 1'($urandom);
                clr_ovr   = $urandom_range(0, 4) == 0;
                rst       = $urandom_range(0, 30) == 0;
                cycle();
            end
            rst = 1'b0;
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
